// File: rtl/kc_gfx_pkg.sv
// Shared graphics definitions: screen geometry, colour palette, rectangle command
// layout and the plotter FSM state encoding.
package kc_gfx_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
    localparam logic [COLOUR_W-1:0] BLUE    = 3'b001;
    localparam logic [COLOUR_W-1:0] GREEN   = 3'b010;
    localparam logic [COLOUR_W-1:0] CYAN    = 3'b011;
    localparam logic [COLOUR_W-1:0] RED     = 3'b100;
    localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
    localparam logic [COLOUR_W-1:0] YELLOW  = 3'b110;
    localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;

    typedef struct packed {
        logic [7:0]          x;
        logic [7:0]          y;
        logic [7:0]          w;
        logic [7:0]          h;
        logic [COLOUR_W-1:0] colour;
    } rect_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rect_cmd_fifo.sv
// Small synchronous FIFO of rectangle commands; DEPTH must be a power of two so
// the pointers wrap naturally.
module rect_cmd_fifo
    import kc_gfx_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push_i,
    input  rect_cmd_t data_i,
    input  logic      pop_i,
    output rect_cmd_t data_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    rect_cmd_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) count_d = count_q + 1'b1;
        else if (pop_i && !push_i) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/rect_plotter.sv
// Rectangle fill engine: queues draw commands and emits one pixel per clock in
// raster order, then pulses done. Optional off-screen clipping: RECT_PLOTTER_CLIP_EN.
module rect_plotter #(
    parameter int X_W        = 8,
    parameter int Y_W        = 8,
    parameter int COLOUR_W   = kc_gfx_pkg::COLOUR_W,
    parameter int FIFO_DEPTH = 2
`ifdef RECT_PLOTTER_CLIP_EN
    ,
    parameter int SCREEN_W   = kc_gfx_pkg::SCREEN_W,
    parameter int SCREEN_H   = kc_gfx_pkg::SCREEN_H
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [X_W-1:0]      cmd_x,
    input  logic [Y_W-1:0]      cmd_y,
    input  logic [X_W-1:0]      cmd_w,
    input  logic [Y_W-1:0]      cmd_h,
    input  logic [COLOUR_W-1:0] cmd_colour,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                done,
    output logic                busy
);
    import kc_gfx_pkg::*;

    rect_cmd_t           push_cmd, head_cmd;
    logic                fifo_full, fifo_empty, push, pop;
    state_t              state_q, state_d;
    logic [X_W-1:0]      x0_q, x0_d, w_q, w_d, col_q, col_d, x_q, x_d, px;
    logic [Y_W-1:0]      y0_q, y0_d, h_q, h_d, row_q, row_d, y_q, y_d, py;
    logic [COLOUR_W-1:0] fill_q, fill_d, colour_q, colour_d;
    logic                plot_q, plot_d, done_q, done_d, on_screen;

    assign push_cmd = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour};
    assign push     = cmd_valid && cmd_ready;

    rect_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .data_i  (push_cmd),
        .pop_i   (pop),
        .data_o  (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Pixel address wraps modulo the field width.
    assign px = x0_q + col_q;
    assign py = y0_q + row_q;

`ifdef RECT_PLOTTER_CLIP_EN
    localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);
    assign on_screen = (px < X_LIM) && (py < Y_LIM);
`else
    assign on_screen = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        fill_d   = fill_q;
        col_d    = col_q;
        row_d    = row_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    x0_d    = head_cmd.x;
                    y0_d    = head_cmd.y;
                    w_d     = head_cmd.w;
                    h_d     = head_cmd.h;
                    fill_d  = head_cmd.colour;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = (head_cmd.w == '0 || head_cmd.h == '0) ? ST_DONE : ST_DRAW;
                end
            end
            ST_DRAW: begin
                x_d      = px;
                y_d      = py;
                colour_d = fill_q;
                plot_d   = on_screen;
                if (col_q == w_q - 1'b1) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                    if (row_q == h_q - 1'b1) state_d = ST_DONE;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            fill_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            fill_q   <= fill_d;
            col_q    <= col_d;
            row_q    <= row_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready  = !fifo_full;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour_out = colour_q;
    assign plot       = plot_q;
    assign done       = done_q;

endmodule
